// File: rtl/noc_local_eject_unit_pkg.sv
// Shared types and constants for the local-output ejection stage.
// Optional per-VC packet counters are enabled with NOC_EJECT_PKT_CNT_EN.
package noc_local_eject_unit_pkg;

    localparam int NOC_VC_CHANNEL = 2;
    localparam int NOC_PORTS      = 5;
    localparam int NOC_FLIT_W     = 64;

    typedef struct packed {
        logic                  last;
        logic [NOC_FLIT_W-1:0] data;
    } noc_flit_t;

    typedef enum logic [0:0] {
        EJ_IDLE   = 1'b0,
        EJ_LOCKED = 1'b1
    } ej_state_t;

    // Round-robin successor of VC index v among n channels.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
    endfunction

endpackage

// File: rtl/noc_eject_vc_fifo.sv
// Per-VC flit buffer: circular storage with registered pointers and occupancy count.
// Read data comes straight from storage (no output register).
module noc_eject_vc_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/noc_local_eject_unit.sv
// Local ejection stage: per-VC ingress mux from the granted port, per-VC buffers,
// packet-atomic round-robin egress to the NI. Define NOC_EJECT_PKT_CNT_EN for pkt_cnt_o.
module noc_local_eject_unit
    import noc_local_eject_unit_pkg::*;
#(
    parameter int CHANNELS = NOC_VC_CHANNEL,
    parameter int FLIT_W   = NOC_FLIT_W,
    parameter int DEPTH    = 4,
    localparam int VCW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                                 noc_clk,
    input  logic                                 noc_rst,
    input  logic [CHANNELS-1:0][NOC_PORTS-1:0]   grant_i,
    output logic [CHANNELS-1:0]                  free_o,
    output logic [CHANNELS-1:0]                  vc_ready_o,
    input  logic [NOC_PORTS-1:0]                 port_valid_i,
    input  logic [NOC_PORTS-1:0][VCW-1:0]        port_vc_i,
    input  logic [NOC_PORTS-1:0]                 port_last_i,
    input  logic [NOC_PORTS-1:0][FLIT_W-1:0]     port_flit_i,
    output logic [NOC_PORTS-1:0]                 port_ready_o,
    output logic                                 out_valid_o,
    output logic [VCW-1:0]                       out_vc_o,
    output logic                                 out_last_o,
    output logic [FLIT_W-1:0]                    out_flit_o,
    input  logic                                 out_ready_i
`ifdef NOC_EJECT_PKT_CNT_EN
    ,
    output logic [CHANNELS-1:0][15:0]            pkt_cnt_o
`endif
);

    logic [CHANNELS-1:0][NOC_PORTS-1:0] sel_s;
    logic [CHANNELS-1:0]                push_s;
    logic [CHANNELS-1:0]                pop_s;
    logic [CHANNELS-1:0]                full_s;
    logic [CHANNELS-1:0]                empty_s;
    logic [CHANNELS-1:0][FLIT_W:0]      push_data_s;
    logic [CHANNELS-1:0][FLIT_W:0]      head_data_s;
    logic [CHANNELS-1:0][CW-1:0]        count_s;
    ej_state_t                          state_r;
    logic [VCW-1:0]                     lock_vc_r;
    logic [VCW-1:0]                     rr_r;
    logic [VCW-1:0]                     pick_s;
    logic                               any_s;
    logic                               head_valid_s;
    logic [FLIT_W:0]                    head_s;

    // A port feeds VC v only when v's grant is exactly that port and the flit is tagged v.
    for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
        for (genvar p = 0; p < NOC_PORTS; p++) begin : g_port
            assign sel_s[v][p] = (grant_i[v] == (NOC_PORTS'(1) << p)) &&
                                 (port_vc_i[p] == VCW'(v)) && !full_s[v];
        end

        noc_eject_vc_fifo #(
            .W     (FLIT_W + 1),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (noc_clk),
            .rst   (noc_rst),
            .push  (push_s[v]),
            .wdata (push_data_s[v]),
            .pop   (pop_s[v]),
            .rdata (head_data_s[v]),
            .full  (full_s[v]),
            .empty (empty_s[v]),
            .count (count_s[v])
        );

        assign vc_ready_o[v] = (count_s[v] < CW'(DEPTH));
        assign pop_s[v]      = head_valid_s && out_ready_i && (lock_vc_r == VCW'(v));
    end

    // Ingress mux: at most one selected port per VC, so OR-reduction is a clean mux.
    always_comb begin
        port_ready_o = '0;
        push_s       = '0;
        push_data_s  = '0;
        for (int v = 0; v < CHANNELS; v++) begin
            for (int p = 0; p < NOC_PORTS; p++) begin
                port_ready_o[p] = port_ready_o[p] | sel_s[v][p];
                push_s[v]       = push_s[v] | (sel_s[v][p] & port_valid_i[p]);
                push_data_s[v]  = push_data_s[v] |
                                  ({(FLIT_W + 1){sel_s[v][p]}} & {port_last_i[p], port_flit_i[p]});
            end
        end
    end

    // First non-empty VC at or after the round-robin pointer (descending scan, lowest offset wins).
    always_comb begin
        pick_s = rr_r;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (!empty_s[(int'(rr_r) + i) % CHANNELS]) begin
                pick_s = VCW'((int'(rr_r) + i) % CHANNELS);
            end else begin
                pick_s = pick_s;
            end
        end
    end

    assign any_s        = ~&empty_s;
    assign head_s       = head_data_s[lock_vc_r];
    assign head_valid_s = (state_r == EJ_LOCKED) && !empty_s[lock_vc_r];

    assign out_valid_o  = head_valid_s;
    assign out_vc_o     = head_valid_s ? lock_vc_r : {VCW{1'b0}};
    assign out_last_o   = head_valid_s & head_s[FLIT_W];
    assign out_flit_o   = head_valid_s ? head_s[FLIT_W-1:0] : {FLIT_W{1'b0}};

    // Free pulse one cycle after a tail flit enters a VC buffer.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            free_o <= '0;
        end else begin
            for (int v = 0; v < CHANNELS; v++) begin
                free_o[v] <= push_s[v] & push_data_s[v][FLIT_W];
            end
        end
    end

    // Egress FSM: lock onto one VC until its tail leaves, so packets never interleave.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state_r   <= EJ_IDLE;
            lock_vc_r <= {VCW{1'b0}};
            rr_r      <= {VCW{1'b0}};
        end else begin
            case (state_r)
                EJ_IDLE: begin
                    if (any_s) begin
                        state_r   <= EJ_LOCKED;
                        lock_vc_r <= pick_s;
                    end
                end
                EJ_LOCKED: begin
                    if (head_valid_s && out_ready_i && head_s[FLIT_W]) begin
                        state_r <= EJ_IDLE;
                        rr_r    <= VCW'(wrap_inc(int'(lock_vc_r), CHANNELS));
                    end
                end
                default: begin
                    state_r <= EJ_IDLE;
                end
            endcase
        end
    end

`ifdef NOC_EJECT_PKT_CNT_EN
    // Per-VC count of tails delivered to the NI; wraps at 16 bits.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            pkt_cnt_o <= '0;
        end else begin
            for (int v = 0; v < CHANNELS; v++) begin
                if (pop_s[v] && head_s[FLIT_W]) begin
                    pkt_cnt_o[v] <= pkt_cnt_o[v] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_local_eject_unit.sv
// Self-checking bench: queue-based reference of the ejection stage, directed
// pinning sequences, then randomized traffic with a mid-run reset.
module tb_noc_local_eject_unit;

    localparam int C = 2;
    localparam int W = 64;
    localparam int D = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [C-1:0][4:0]     grant;
    logic [C-1:0]          free;
    logic [C-1:0]          vc_ready;
    logic [4:0]            pvalid;
    logic [4:0][0:0]       pvc;
    logic [4:0]            plast;
    logic [4:0][W-1:0]     pflit;
    logic [4:0]            pready;
    logic                  ovalid;
    logic [0:0]            ovc;
    logic                  olast;
    logic [W-1:0]          oflit;
    logic                  oready;

    always #5 clk = ~clk;

    noc_local_eject_unit #(.CHANNELS(C), .FLIT_W(W), .DEPTH(D)) dut (
        .noc_clk      (clk),
        .noc_rst      (rst),
        .grant_i      (grant),
        .free_o       (free),
        .vc_ready_o   (vc_ready),
        .port_valid_i (pvalid),
        .port_vc_i    (pvc),
        .port_last_i  (plast),
        .port_flit_i  (pflit),
        .port_ready_o (pready),
        .out_valid_o  (ovalid),
        .out_vc_o     (ovc),
        .out_last_o   (olast),
        .out_flit_o   (oflit),
        .out_ready_i  (oready)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: per-VC flit queues, packet currently owning the output (-1 = none), RR pointer.
    logic [W:0]   q [C][$];
    int           cur;
    int           rr;
    logic [C-1:0] free_pend;
    logic [C-1:0] last_push;

    // Stimulus controller per VC: 0 idle, 1 sending packet, 2 one-cycle gap after tail.
    int           gst [C];
    int           gport [C];
    int           glen [C];
    int           gidx [C];
    logic [W-1:0] gdata [C];

    task automatic chk(input string name, input logic [W:0] got, input logic [W:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < C; v++) begin
            q[v].delete();
            gst[v] = 0;
        end
        cur       = -1;
        rr        = 0;
        free_pend = '0;
        last_push = '0;
    endtask

    // Compare every output at the falling edge, then advance the model across the next rising edge.
    task automatic check_and_update();
        logic [C-1:0] exp_vr;
        logic [4:0]   exp_pr;
        logic [C-1:0] push;
        logic [W:0]   pdat [C];
        logic         ev;
        logic [W:0]   eh;
        logic [W:0]   popped;
        @(negedge clk);
        exp_pr = '0;
        push   = '0;
        for (int v = 0; v < C; v++) begin
            pdat[v]   = '0;
            exp_vr[v] = (q[v].size() < D);
            for (int p = 0; p < 5; p++) begin
                if (grant[v] == (5'b00001 << p) && int'(pvc[p]) == v && q[v].size() < D) begin
                    exp_pr[p] = 1'b1;
                    if (pvalid[p]) begin
                        push[v] = 1'b1;
                        pdat[v] = {plast[p], pflit[p]};
                    end
                end
            end
        end
        ev = (cur >= 0) && (q[cur].size() > 0);
        eh = ev ? q[cur][0] : '0;
        chk("port_ready", pready, exp_pr);
        chk("vc_ready", vc_ready, exp_vr);
        chk("free", free, free_pend);
        chk("out_valid", ovalid, ev);
        chk("out_vc", ovc, ev ? 1'(cur) : 1'b0);
        chk("out_last", olast, eh[W]);
        chk("out_flit", oflit, eh[W-1:0]);
        if (ev && oready) begin
            popped = q[cur].pop_front();
            if (popped[W]) begin
                rr  = (cur + 1) % C;
                cur = -1;
            end
        end else if (cur < 0) begin
            for (int i = 0; i < C; i++) begin
                if (cur < 0 && q[(rr + i) % C].size() > 0) cur = (rr + i) % C;
            end
        end
        for (int v = 0; v < C; v++) begin
            if (push[v]) q[v].push_back(pdat[v]);
            free_pend[v] = push[v] & pdat[v][W];
        end
        last_push = push;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random();
        for (int p = 0; p < 5; p++) begin
            pvalid[p] = 1'($urandom_range(0, 1));
            pvc[p]    = 1'($urandom_range(0, 1));
            plast[p]  = 1'($urandom_range(0, 1));
            pflit[p]  = {$urandom, $urandom};
        end
        for (int v = 0; v < C; v++) begin
            if (gst[v] == 1 && last_push[v]) begin
                if (gidx[v] == glen[v] - 1) begin
                    gst[v] = 2;
                end else begin
                    gidx[v]++;
                    gdata[v] = {$urandom, $urandom};
                end
            end else if (gst[v] == 2) begin
                gst[v] = 0;
            end else if (gst[v] == 0 && $urandom_range(0, 2) == 0) begin
                gst[v]   = 1;
                gport[v] = (v == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 4));
                glen[v]  = int'($urandom_range(1, 5));
                gidx[v]  = 0;
                gdata[v] = {$urandom, $urandom};
            end
            grant[v] = (gst[v] == 1) ? (5'b00001 << gport[v]) : 5'b00000;
            if (gst[v] == 1) begin
                pvalid[gport[v]] = ($urandom_range(0, 3) != 0);
                pvc[gport[v]]    = 1'(v);
                plast[gport[v]]  = (gidx[v] == glen[v] - 1);
                pflit[gport[v]]  = gdata[v];
            end
        end
    endtask

    initial begin
        int j;
        rst    = 1'b1;
        grant  = '0;
        pvalid = '0;
        pvc    = '0;
        plast  = '0;
        pflit  = '0;
        oready = 1'b0;
        model_reset();
        check_and_update();
        chk("rst_out_valid", ovalid, 1'b0);
        chk("rst_vc_ready", vc_ready, 2'b11);
        chk("rst_free", free, 2'b00);
        chk("rst_port_ready", pready, 5'b00000);
        next_cycle();
        rst = 1'b0;

        // Three-flit packet on VC0 from port 1, output always ready.
        grant[0] = 5'b00010; pvalid[1] = 1'b1; pvc[1] = 1'b0; oready = 1'b1;
        plast[1] = 1'b0; pflit[1] = 64'h0000_0000_0000_00A1;
        check_and_update();
        chk("t1_ready", pready[1], 1'b1);
        next_cycle();
        pflit[1] = 64'h0000_0000_0000_00B2;
        check_and_update();
        chk("t1_latency", ovalid, 1'b0);
        next_cycle();
        plast[1] = 1'b1; pflit[1] = 64'h0000_0000_0000_00C3;
        check_and_update();
        chk("t1_first", oflit, 64'h0000_0000_0000_00A1);
        next_cycle();
        grant = '0; pvalid = '0;
        check_and_update();
        chk("t1_free", free, 2'b01);
        chk("t1_second", oflit, 64'h0000_0000_0000_00B2);
        next_cycle();
        check_and_update();
        chk("t1_tail_last", olast, 1'b1);
        chk("t1_tail", oflit, 64'h0000_0000_0000_00C3);
        next_cycle();
        check_and_update();
        chk("t1_done", ovalid, 1'b0);
        chk("t1_free_once", free, 2'b00);
        next_cycle();

        // Fill VC0 with output stalled, then release.
        j = 0;
        grant[0] = 5'b00010;
        for (int cyc = 0; cyc < 14 && j < 5; cyc++) begin
            oready    = (cyc >= 6);
            pvalid    = '0;
            pvalid[1] = 1'b1;
            pvc[1]    = 1'b0;
            plast[1]  = (j == 4);
            pflit[1]  = 64'h0000_0000_0000_C000 + 64'(j);
            check_and_update();
            if (cyc == 4) begin
                chk("t3_vc_ready_full", vc_ready[0], 1'b0);
                chk("t3_port_ready_full", pready[1], 1'b0);
            end
            if (cyc == 6) chk("t3_head", oflit, 64'h0000_0000_0000_C000);
            if (last_push[0]) j++;
            next_cycle();
        end
        grant = '0; pvalid = '0; oready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            check_and_update();
            next_cycle();
        end

        // Randomized traffic with alternating drain/stall phases and a reset in the middle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                rst    = 1'b1;
                model_reset();
                grant  = '0;
                pvalid = '0;
                oready = 1'b1;
            end else begin
                rst = 1'b0;
                drive_random();
                oready = ((cyc / 200) % 2 == 0) ? ($urandom_range(0, 9) != 0)
                                                : ($urandom_range(0, 9) < 2);
            end
            check_and_update();
            if (cyc == 1500) begin
                chk("t5_out_valid", ovalid, 1'b0);
                chk("t5_vc_ready", vc_ready, 2'b11);
                chk("t5_free", free, 2'b00);
            end
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
